cmip_bit_sync_filt: RTL



---
 rtl/cmip_pkg.sv | 16 +
 rtl/cmip_bit_filt_ch.sv | 65 ++++++
 rtl/cmip_bit_sync_filt.sv | 59 +++++
 3 files changed

// File: rtl/cmip_pkg.sv
// Shared constants and helpers for the cmip clock-domain-crossing blocks.
package cmip_pkg;

    // Minimum synchroniser depth that gives a metastable first stage a full cycle to settle.
    localparam int CMIP_SYNC_MIN = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/cmip_bit_filt_ch.sv
// One channel of the bit filter: stability counter, filtered level,
// one-cycle edge pulses and a software-clearable sticky event flag.
module cmip_bit_filt_ch #(
    parameter int   FILT_W  = 8,
    parameter logic RST_VAL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              flag_clr,
    output logic              dout,
    output logic              rise,
    output logic              fall,
    output logic              evt_flag
);

    localparam logic [FILT_W-1:0] CNT_MAX = {FILT_W{1'b1}};

    logic [FILT_W-1:0] cnt_q, cnt_d;
    logic [FILT_W-1:0] len_m1;
    logic              dout_d, rise_d, fall_d, flag_d;

    // A length of zero behaves as one, so the flip threshold never underflows.
    assign len_m1 = (filt_len == '0) ? '0 : filt_len - FILT_W'(1);

    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s == dout) begin
            cnt_d = '0;
        end else if (cnt_q >= len_m1) begin
            cnt_d  = '0;
            dout_d = ~dout;
            rise_d = ~dout;
            fall_d = dout;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + FILT_W'(1);
        end
    end

    // The flag is set from the registered pulse, so a clear in that cycle loses.
    assign flag_d = (rise | fall) ? 1'b1 : (flag_clr ? 1'b0 : evt_flag);

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            dout     <= RST_VAL;
            rise     <= 1'b0;
            fall     <= 1'b0;
            evt_flag <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dout     <= dout_d;
            rise     <= rise_d;
            fall     <= fall_d;
            evt_flag <= flag_d;
        end
    end

endmodule

// File: rtl/cmip_bit_sync_filt.sv
// Multi-channel bit synchroniser followed by a programmable glitch filter,
// edge detector and sticky event flags, all in the destination clock domain.
module cmip_bit_sync_filt
    import cmip_pkg::*;
#(
    parameter int                CH_NUM     = 4,
    parameter int                SYNC_STAGE = 2,
    parameter int                FILT_W     = 8,
    parameter logic [CH_NUM-1:0] RST_VAL    = {CH_NUM{1'b0}}
) (
    input  logic              i_dst_clk,
    input  logic              i_dst_rst_n,
    input  logic [CH_NUM-1:0] i_din,
    input  logic [FILT_W-1:0] i_filt_len,
    input  logic [CH_NUM-1:0] i_flag_clr,
    output logic [CH_NUM-1:0] o_dout,
    output logic [CH_NUM-1:0] o_rise,
    output logic [CH_NUM-1:0] o_fall,
    output logic [CH_NUM-1:0] o_evt_flag
);

    if (SYNC_STAGE < CMIP_SYNC_MIN || CH_NUM < 1) begin : g_param_err
        $error("cmip_bit_sync_filt: SYNC_STAGE must be >= %0d and CH_NUM >= 1", CMIP_SYNC_MIN);
    end

    (* ASYNC_REG = "TRUE" *) logic [CH_NUM-1:0] sync_q [SYNC_STAGE];

    // NOTE: the stage array is a small flop chain, not a RAM, so each stage is reset.
    always_ff @(posedge i_dst_clk or negedge i_dst_rst_n) begin
        if (!i_dst_rst_n) begin
            for (int k = 0; k < SYNC_STAGE; k++) begin
                sync_q[k] <= RST_VAL;
            end
        end else begin
            sync_q[0] <= i_din;
            for (int k = 1; k < SYNC_STAGE; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        cmip_bit_filt_ch #(
            .FILT_W  (FILT_W),
            .RST_VAL (RST_VAL[g])
        ) u_ch (
            .clk      (i_dst_clk),
            .rst_n    (i_dst_rst_n),
            .s        (sync_q[SYNC_STAGE-1][g]),
            .filt_len (i_filt_len),
            .flag_clr (i_flag_clr[g]),
            .dout     (o_dout[g]),
            .rise     (o_rise[g]),
            .fall     (o_fall[g]),
            .evt_flag (o_evt_flag[g])
        );
    end

endmodule
